// File: rtl/l2_arbiter_pkg.sv
// l2_arbiter_pkg
//   Shared types and constants for the round-robin L2 arbiter.
//   state_t : arbiter FSM state (IDLE: nothing owned, BUSY: one transaction
//             owned and forwarded to L2).
//   ADDR_W  : width of a line address on both the upstream and L2 sides.
package l2_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int ADDR_W = 32;

endpackage

// File: rtl/l2_arbiter_rr_picker.sv
// rr_picker
//   Combinational circular priority picker.
//   Finds the first port i with pend[i]=1 and mask[i]=0, scanning from
//   'start' upward and wrapping at N.
//   Ports:
//     pend  [N-1:0]     in   pending request vector
//     start [IDX_W-1:0] in   first index to consider (must be < N)
//     mask  [N-1:0]     in   ports excluded from this pick
//     found             out  at least one eligible port exists
//     idx   [IDX_W-1:0] out  winning port (0 when found=0)
module rr_picker
    import l2_arbiter_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     pend,
    input  logic [IDX_W-1:0] start,
    input  logic [N-1:0]     mask,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [N-1:0]     elig;
    logic [N-1:0]     rot;
    logic [N:0]       seen;
    logic [IDX_W-1:0] off_chain [N+1];
    logic [IDX_W:0]   sum;

    assign elig = pend & ~mask;

    // Rotate so that bit 0 of rot corresponds to port 'start'; the first set
    // bit of rot is then the circular winner, offset from start.
    assign rot = N'({elig, elig} >> start);

    assign seen[0]      = 1'b0;
    assign off_chain[0] = '0;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_prio
            logic first;
            assign first            = rot[gi] & ~seen[gi];
            assign seen[gi+1]       = seen[gi] | rot[gi];
            assign off_chain[gi+1]  = off_chain[gi] | ({IDX_W{first}} & IDX_W'(gi));
        end
    endgenerate

    assign found = seen[N];

    // start + offset, reduced modulo N (both terms are < N, so one subtract).
    assign sum = {1'b0, start} + {1'b0, off_chain[N]};

    always_comb begin
        idx = '0;
        if (found) begin
            if (sum >= (IDX_W+1)'(N)) begin
                idx = IDX_W'(sum - (IDX_W+1)'(N));
            end else begin
                idx = sum[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/l2_arbiter_rr.sv
// l2_arbiter_rr
//   N-requester round-robin arbiter in front of a single-port L2 line
//   interface. One transaction is in flight at a time; the owner's request is
//   forwarded combinationally while BUSY and the completion is routed back
//   only to the owner. On completion the next owner is chosen in the same
//   cycle so consecutive transactions have no dead cycle.
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     req_read/req_write [N]    per-port level requests, held until resp
//     req_address [N*32]        per-port line address, port i at [32*i +: 32]
//     req_wdata [N*S_LINE]      per-port write line
//     req_resp [N]              one-hot completion pulse to the owner
//     req_rdata [S_LINE]        read line, meaningful only with req_resp
//     mem_read/mem_write        request to L2 (owner's request while BUSY)
//     mem_address, mem_wdata    owner's address / write data while BUSY
//     mem_resp, mem_rdata       L2 single-cycle completion and read line
//     grant_valid, grant_idx    current ownership (idx meaningless if !valid)
module l2_arbiter_rr
    import l2_arbiter_pkg::*;
#(
    parameter int N_PORTS = 2,
    parameter int S_LINE  = 256,
    parameter int IDX_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_PORTS-1:0]          req_read,
    input  logic [N_PORTS-1:0]          req_write,
    input  logic [N_PORTS*ADDR_W-1:0]   req_address,
    input  logic [N_PORTS*S_LINE-1:0]   req_wdata,
    output logic [N_PORTS-1:0]          req_resp,
    output logic [S_LINE-1:0]           req_rdata,
    output logic                        mem_read,
    output logic                        mem_write,
    output logic [ADDR_W-1:0]           mem_address,
    output logic [S_LINE-1:0]           mem_wdata,
    input  logic                        mem_resp,
    input  logic [S_LINE-1:0]           mem_rdata,
    output logic                        grant_valid,
    output logic [IDX_W-1:0]            grant_idx
);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [N_PORTS-1:0] pend;
    logic [N_PORTS-1:0] owner_mask;
    logic [N_PORTS-1:0] no_mask;
    logic [IDX_W-1:0]   owner_inc;

    logic [ADDR_W-1:0]  addr_arr  [N_PORTS];
    logic [S_LINE-1:0]  wdata_arr [N_PORTS];

    logic               idle_found, resp_found;
    logic [IDX_W-1:0]   idle_idx, resp_idx;

    assign pend    = req_read | req_write;
    assign no_mask = '0;

    generate
        for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
            assign addr_arr[gi]   = req_address[ADDR_W*gi +: ADDR_W];
            assign wdata_arr[gi]  = req_wdata[S_LINE*gi +: S_LINE];
            assign owner_mask[gi] = (owner_q == IDX_W'(gi));
        end
    endgenerate

    assign owner_inc = (owner_q == IDX_W'(N_PORTS - 1)) ? '0 : owner_q + IDX_W'(1);

    // Arbitration from IDLE: plain round-robin starting at rr_ptr.
    rr_picker #(
        .N     (N_PORTS),
        .IDX_W (IDX_W)
    ) u_pick_idle (
        .pend  (pend),
        .start (rr_ptr_q),
        .mask  (no_mask),
        .found (idle_found),
        .idx   (idle_idx)
    );

    // Arbitration at completion: the finishing owner still holds its request
    // this cycle, so it is masked out and the scan starts just after it.
    rr_picker #(
        .N     (N_PORTS),
        .IDX_W (IDX_W)
    ) u_pick_resp (
        .pend  (pend),
        .start (owner_inc),
        .mask  (owner_mask),
        .found (resp_found),
        .idx   (resp_idx)
    );

    assign grant_valid = (state_q == BUSY);
    assign grant_idx   = owner_q;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        req_resp    = '0;
        req_rdata   = '0;

        case (state_q)
            IDLE: begin
                // mem_resp here is spurious and deliberately ignored.
                if (idle_found) begin
                    owner_d = idle_idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                mem_read    = req_read[owner_q];
                mem_write   = req_write[owner_q];
                mem_address = addr_arr[owner_q];
                mem_wdata   = wdata_arr[owner_q];
                if (mem_resp) begin
                    req_resp  = owner_mask;
                    req_rdata = mem_rdata;
                    rr_ptr_d  = owner_inc;
                    if (resp_found) begin
                        owner_d = resp_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Protocol checks on the upstream and L2 sides (simulation only effect).
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == IDLE) begin
                assert (!mem_resp)
                    else $warning("l2_arbiter_rr: mem_resp while idle, ignored");
            end
            if (state_q == BUSY) begin
                assert (pend[owner_q])
                    else $error("l2_arbiter_rr: owner dropped request before mem_resp");
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_rw_chk
            always_ff @(posedge clk) begin
                if (!rst) begin
                    assert (!(req_read[gi] && req_write[gi]))
                        else $error("l2_arbiter_rr: port %0d read and write together", gi);
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_l2_arbiter_rr.sv
module tb_l2_arbiter_rr;

    localparam int SL = 256;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Two-port instance
    logic [1:0]      req_read, req_write, req_resp;
    logic [63:0]     req_address;
    logic [2*SL-1:0] req_wdata;
    logic [SL-1:0]   req_rdata, mem_wdata, mem_rdata;
    logic            mem_read, mem_write, mem_resp, grant_valid;
    logic [31:0]     mem_address;
    logic [0:0]      grant_idx;

    // Four-port instance
    logic [3:0]      req_read4, req_write4, req_resp4;
    logic [127:0]    req_address4;
    logic [4*SL-1:0] req_wdata4;
    logic [SL-1:0]   req_rdata4, mem_wdata4, mem_rdata4;
    logic            mem_read4, mem_write4, mem_resp4, grant_valid4;
    logic [31:0]     mem_address4;
    logic [1:0]      grant_idx4;

    int n_cmp = 0;
    int n_err = 0;

    l2_arbiter_rr #(.N_PORTS(2), .S_LINE(SL)) dut (
        .clk(clk), .rst(rst),
        .req_read(req_read), .req_write(req_write),
        .req_address(req_address), .req_wdata(req_wdata),
        .req_resp(req_resp), .req_rdata(req_rdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata),
        .grant_valid(grant_valid), .grant_idx(grant_idx)
    );

    l2_arbiter_rr #(.N_PORTS(4), .S_LINE(SL)) dut4 (
        .clk(clk), .rst(rst),
        .req_read(req_read4), .req_write(req_write4),
        .req_address(req_address4), .req_wdata(req_wdata4),
        .req_resp(req_resp4), .req_rdata(req_rdata4),
        .mem_read(mem_read4), .mem_write(mem_write4),
        .mem_address(mem_address4), .mem_wdata(mem_wdata4),
        .mem_resp(mem_resp4), .mem_rdata(mem_rdata4),
        .grant_valid(grant_valid4), .grant_idx(grant_idx4)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        #1;
        n_cmp++; if (grant_valid !== 1'b0) begin n_err++; $display("FAIL rst_grant_valid: got %b want 0", grant_valid); end
        n_cmp++; if (mem_read !== 1'b0) begin n_err++; $display("FAIL rst_mem_read: got %b want 0", mem_read); end
        n_cmp++; if (mem_write !== 1'b0) begin n_err++; $display("FAIL rst_mem_write: got %b want 0", mem_write); end
        n_cmp++; if (req_resp !== 2'b00) begin n_err++; $display("FAIL rst_req_resp: got %b want 00", req_resp); end
        n_cmp++; if (mem_address !== 32'h0) begin n_err++; $display("FAIL rst_mem_address: got %h want 0", mem_address); end
        n_cmp++; if (req_rdata !== '0) begin n_err++; $display("FAIL rst_req_rdata: got %h want 0", req_rdata); end
        n_cmp++; if (grant_valid4 !== 1'b0) begin n_err++; $display("FAIL rst_grant_valid4: got %b want 0", grant_valid4); end
        $display("txn reset done");
    endtask

    task automatic test_read;
        logic [SL-1:0] line_a5;
        line_a5 = {32{8'hA5}};
        tick;
        req_read[0] = 1'b1;
        req_address[31:0] = 32'h100;
        #1;
        n_cmp++; if (mem_read !== 1'b0) begin n_err++; $display("FAIL rd_idle_mem_read: got %b want 0", mem_read); end
        n_cmp++; if (grant_valid !== 1'b0) begin n_err++; $display("FAIL rd_idle_grant: got %b want 0", grant_valid); end
        tick;
        n_cmp++; if (mem_read !== 1'b1) begin n_err++; $display("FAIL rd_mem_read: got %b want 1", mem_read); end
        n_cmp++; if (mem_address !== 32'h100) begin n_err++; $display("FAIL rd_mem_address: got %h want 100", mem_address); end
        n_cmp++; if (grant_valid !== 1'b1) begin n_err++; $display("FAIL rd_grant_valid: got %b want 1", grant_valid); end
        n_cmp++; if (grant_idx !== 1'b0) begin n_err++; $display("FAIL rd_grant_idx: got %0d want 0", grant_idx); end
        n_cmp++; if (req_resp !== 2'b00) begin n_err++; $display("FAIL rd_early_resp: got %b want 00", req_resp); end
        mem_resp  = 1'b1;
        mem_rdata = line_a5;
        #1;
        n_cmp++; if (req_resp !== 2'b01) begin n_err++; $display("FAIL rd_req_resp: got %b want 01", req_resp); end
        n_cmp++; if (req_rdata !== line_a5) begin n_err++; $display("FAIL rd_req_rdata: got %h want %h", req_rdata, line_a5); end
        $display("txn read port0 addr 00000100");
        tick;
        mem_resp  = 1'b0;
        mem_rdata = '0;
        req_read  = 2'b00;
        #1;
        n_cmp++; if (grant_valid !== 1'b0) begin n_err++; $display("FAIL rd_after_grant: got %b want 0", grant_valid); end
        n_cmp++; if (req_resp !== 2'b00) begin n_err++; $display("FAIL rd_after_resp: got %b want 00", req_resp); end
        n_cmp++; if (mem_read !== 1'b0) begin n_err++; $display("FAIL rd_after_mem_read: got %b want 0", mem_read); end
    endtask

    task automatic test_write;
        logic [SL-1:0] line_dead;
        line_dead = {8{32'hDEADBEEF}};
        req_write[1] = 1'b1;
        req_address[63:32] = 32'h2000;
        req_wdata[2*SL-1:SL] = line_dead;
        #1;
        n_cmp++; if (grant_valid !== 1'b0) begin n_err++; $display("FAIL wr_idle_grant: got %b want 0", grant_valid); end
        tick;
        n_cmp++; if (mem_write !== 1'b1) begin n_err++; $display("FAIL wr_mem_write: got %b want 1", mem_write); end
        n_cmp++; if (mem_read !== 1'b0) begin n_err++; $display("FAIL wr_mem_read: got %b want 0", mem_read); end
        n_cmp++; if (mem_address !== 32'h2000) begin n_err++; $display("FAIL wr_mem_address: got %h want 2000", mem_address); end
        n_cmp++; if (mem_wdata !== line_dead) begin n_err++; $display("FAIL wr_mem_wdata: got %h want %h", mem_wdata, line_dead); end
        n_cmp++; if (grant_idx !== 1'b1) begin n_err++; $display("FAIL wr_grant_idx: got %0d want 1", grant_idx); end
        mem_resp = 1'b1;
        #1;
        n_cmp++; if (req_resp !== 2'b10) begin n_err++; $display("FAIL wr_req_resp: got %b want 10", req_resp); end
        $display("txn write port1 addr 00002000");
        tick;
        mem_resp  = 1'b0;
        req_write = 2'b00;
        #1;
        n_cmp++; if (grant_valid !== 1'b0) begin n_err++; $display("FAIL wr_after_grant: got %b want 0", grant_valid); end
    endtask

    task automatic test_back_to_back;
        int ev;
        logic [SL-1:0] line;
        req_read = 2'b11;
        req_address[31:0]  = 32'h0000_0A00;
        req_address[63:32] = 32'h0000_0B00;
        #1;
        n_cmp++; if (grant_valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle_grant: got %b want 0", grant_valid); end
        tick;
        for (int t = 0; t < 8; t++) begin
            ev = t % 2;
            // first cycle of transaction t: previous owner drops its request
            mem_resp = 1'b0;
            if (t > 0) req_read[1-ev] = 1'b0;
            #1;
            n_cmp++; if (mem_read !== 1'b1) begin n_err++; $display("FAIL b2b_gap t=%0d: mem_read %b want 1", t, mem_read); end
            n_cmp++; if (grant_idx !== 1'(ev)) begin n_err++; $display("FAIL b2b_grant t=%0d: got %0d want %0d", t, grant_idx, ev); end
            n_cmp++; if (req_resp !== 2'b00) begin n_err++; $display("FAIL b2b_noresp t=%0d: got %b want 00", t, req_resp); end
            tick;
            // second cycle: completion; the other port re-requests
            if (t > 0 && t < 7) req_read[1-ev] = 1'b1;
            line      = {8{32'hC0DE_0000 + 32'(t)}};
            mem_resp  = 1'b1;
            mem_rdata = line;
            #1;
            n_cmp++; if (mem_read !== 1'b1) begin n_err++; $display("FAIL b2b_rd2 t=%0d: mem_read %b want 1", t, mem_read); end
            n_cmp++; if (req_resp !== ((ev == 1) ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL b2b_resp t=%0d: got %b want port %0d", t, req_resp, ev); end
            n_cmp++; if (req_rdata !== line) begin n_err++; $display("FAIL b2b_rdata t=%0d: got %h want %h", t, req_rdata, line); end
            $display("txn b2b %0d port%0d", t, ev);
            tick;
        end
        mem_resp  = 1'b0;
        mem_rdata = '0;
        req_read  = 2'b00;
        #1;
        n_cmp++; if (grant_valid !== 1'b0) begin n_err++; $display("FAIL b2b_end_grant: got %b want 0", grant_valid); end
        n_cmp++; if (mem_read !== 1'b0) begin n_err++; $display("FAIL b2b_end_mem_read: got %b want 0", mem_read); end
    endtask

    task automatic test_spurious;
        mem_resp  = 1'b1;
        mem_rdata = {32{8'h5A}};
        #1;
        n_cmp++; if (req_resp !== 2'b00) begin n_err++; $display("FAIL spur_resp: got %b want 00", req_resp); end
        n_cmp++; if (grant_valid !== 1'b0) begin n_err++; $display("FAIL spur_grant: got %b want 0", grant_valid); end
        n_cmp++; if (req_rdata !== '0) begin n_err++; $display("FAIL spur_rdata: got %h want 0", req_rdata); end
        tick;
        mem_resp  = 1'b0;
        mem_rdata = '0;
        #1;
        n_cmp++; if (grant_valid !== 1'b0) begin n_err++; $display("FAIL spur_after_grant: got %b want 0", grant_valid); end
        n_cmp++; if (mem_read !== 1'b0) begin n_err++; $display("FAIL spur_after_mem_read: got %b want 0", mem_read); end
        $display("txn spurious mem_resp in idle");
    endtask

    task automatic test_reset_mid;
        // port0 completes so rr_ptr moves to 1
        req_read[0] = 1'b1;
        req_address[31:0] = 32'h300;
        tick;
        n_cmp++; if (grant_idx !== 1'b0) begin n_err++; $display("FAIL rm_pre_grant: got %0d want 0", grant_idx); end
        mem_resp = 1'b1;
        tick;
        mem_resp = 1'b0;
        req_read = 2'b00;
        // port1 becomes owner, then reset mid-transaction
        req_read[1] = 1'b1;
        req_address[63:32] = 32'h400;
        tick;
        n_cmp++; if (grant_idx !== 1'b1) begin n_err++; $display("FAIL rm_own1: got %0d want 1", grant_idx); end
        n_cmp++; if (mem_address !== 32'h400) begin n_err++; $display("FAIL rm_addr1: got %h want 400", mem_address); end
        rst = 1'b1;
        tick;
        n_cmp++; if (grant_valid !== 1'b0) begin n_err++; $display("FAIL rm_grant_valid: got %b want 0", grant_valid); end
        n_cmp++; if (mem_read !== 1'b0) begin n_err++; $display("FAIL rm_mem_read: got %b want 0", mem_read); end
        n_cmp++; if (mem_address !== 32'h0) begin n_err++; $display("FAIL rm_mem_address: got %h want 0", mem_address); end
        rst = 1'b0;
        req_read = 2'b11;
        tick;
        n_cmp++; if (grant_idx !== 1'b0) begin n_err++; $display("FAIL rm_first_grant: got %0d want 0", grant_idx); end
        n_cmp++; if (mem_address !== 32'h300) begin n_err++; $display("FAIL rm_first_addr: got %h want 300", mem_address); end
        mem_resp = 1'b1;
        #1;
        n_cmp++; if (req_resp !== 2'b01) begin n_err++; $display("FAIL rm_resp0: got %b want 01", req_resp); end
        tick;
        req_read[0] = 1'b0;
        mem_resp = 1'b0;
        #1;
        n_cmp++; if (grant_idx !== 1'b1) begin n_err++; $display("FAIL rm_second_grant: got %0d want 1", grant_idx); end
        mem_resp = 1'b1;
        #1;
        n_cmp++; if (req_resp !== 2'b10) begin n_err++; $display("FAIL rm_resp1: got %b want 10", req_resp); end
        tick;
        req_read = 2'b00;
        mem_resp = 1'b0;
        #1;
        n_cmp++; if (grant_valid !== 1'b0) begin n_err++; $display("FAIL rm_end_grant: got %b want 0", grant_valid); end
        $display("txn reset mid-transaction");
    endtask

    task automatic test_n4;
        logic [SL-1:0] line;
        line = {16{16'h3C3C}};
        // port1 completes alone, leaving rr_ptr=2
        req_read4[1] = 1'b1;
        req_address4[63:32] = 32'h1100;
        tick;
        n_cmp++; if (grant_idx4 !== 2'd1) begin n_err++; $display("FAIL n4_pre_grant: got %0d want 1", grant_idx4); end
        mem_resp4 = 1'b1;
        #1;
        n_cmp++; if (req_resp4 !== 4'b0010) begin n_err++; $display("FAIL n4_pre_resp: got %b want 0010", req_resp4); end
        tick;
        req_read4 = 4'b0000;
        mem_resp4 = 1'b0;
        #1;
        n_cmp++; if (grant_valid4 !== 1'b0) begin n_err++; $display("FAIL n4_idle: got %b want 0", grant_valid4); end
        // ports 1 and 3 pending with rr_ptr=2
        req_read4 = 4'b1010;
        req_address4[127:96] = 32'h3300;
        tick;
        n_cmp++; if (grant_idx4 !== 2'd3) begin n_err++; $display("FAIL n4_first: got %0d want 3", grant_idx4); end
        n_cmp++; if (mem_address4 !== 32'h3300) begin n_err++; $display("FAIL n4_first_addr: got %h want 3300", mem_address4); end
        mem_resp4  = 1'b1;
        mem_rdata4 = line;
        #1;
        n_cmp++; if (req_resp4 !== 4'b1000) begin n_err++; $display("FAIL n4_resp3: got %b want 1000", req_resp4); end
        n_cmp++; if (req_rdata4 !== line) begin n_err++; $display("FAIL n4_rdata3: got %h want %h", req_rdata4, line); end
        $display("txn n4 port3");
        tick;
        req_read4[3] = 1'b0;
        mem_resp4 = 1'b0;
        mem_rdata4 = '0;
        #1;
        n_cmp++; if (grant_valid4 !== 1'b1) begin n_err++; $display("FAIL n4_second_valid: got %b want 1", grant_valid4); end
        n_cmp++; if (grant_idx4 !== 2'd1) begin n_err++; $display("FAIL n4_second: got %0d want 1", grant_idx4); end
        n_cmp++; if (mem_address4 !== 32'h1100) begin n_err++; $display("FAIL n4_second_addr: got %h want 1100", mem_address4); end
        mem_resp4 = 1'b1;
        #1;
        n_cmp++; if (req_resp4 !== 4'b0010) begin n_err++; $display("FAIL n4_resp1: got %b want 0010", req_resp4); end
        $display("txn n4 port1");
        tick;
        req_read4 = 4'b0000;
        mem_resp4 = 1'b0;
        #1;
        n_cmp++; if (grant_valid4 !== 1'b0) begin n_err++; $display("FAIL n4_end: got %b want 0", grant_valid4); end
    endtask

    initial begin
        rst = 1'b1;
        req_read = '0;  req_write = '0;  req_address = '0;  req_wdata = '0;
        mem_resp = 1'b0; mem_rdata = '0;
        req_read4 = '0; req_write4 = '0; req_address4 = '0; req_wdata4 = '0;
        mem_resp4 = 1'b0; mem_rdata4 = '0;
        test_reset;
        test_read;
        test_write;
        test_back_to_back;
        test_spurious;
        test_reset_mid;
        test_n4;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/l2_arbiter_rr.md
Name: l2_arbiter_rr

Overview:
- Parametrised N-requester arbiter between the upper cache levels (I-cache, D-cache, later prefetcher/victim buffer) and the single-port shared L2 line interface.
- Successor to the fixed two-port I/D arbiter.
- Adds round-robin fairness, a registered grant, a spurious-response guard and grant visibility outputs.
- One downstream transaction in flight at a time; the response goes only to the owning requester.

Parameters:
N_PORTS, 2, number of upstream requesters (2..8)
S_LINE, 256, line width in bits
IDX_W, $clog2(N_PORTS) (minimum 1), width of the grant index

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_read  in  N_PORTS  per-port line read request, level, held until that port's resp
req_write  in  N_PORTS  per-port line write request, level, held until that port's resp
req_address  in  N_PORTS*32  per-port line address, port i at [32*i +: 32]
req_wdata  in  N_PORTS*S_LINE  per-port write line
req_resp  out  N_PORTS  one-hot completion pulse
req_rdata  out  S_LINE  read line, broadcast; valid only with req_resp
mem_read  out  1  to L2
mem_write  out  1  to L2
mem_address  out  32  to L2
mem_wdata  out  S_LINE  to L2
mem_resp  in  1  L2 completion, single cycle
mem_rdata  in  S_LINE  L2 read line, valid with mem_resp
grant_valid  out  1  a transaction is owned
grant_idx  out  IDX_W  owning port; value is don't-care when grant_valid=0

Behaviour:
- Clocking and reset: one clock clk. rst is synchronous and active-high.
- Reset values: state=IDLE, rr_ptr=0, grant_valid=0, mem_read=0, mem_write=0, req_resp=0. mem_address, mem_wdata and req_rdata are driven 0 in IDLE.
- Per-port request: pend[i] = req_read[i] | req_write[i].
- States:
  - IDLE: if any pend, pick the winner = first pending port at or after rr_ptr (circular). Register owner <= winner, go BUSY. Nothing is driven downstream in this cycle.
  - BUSY: mem_read/mem_write/mem_address/mem_wdata are combinational copies of the owner's inputs. On mem_resp, in the same cycle: req_resp[owner]=1, req_rdata=mem_rdata, rr_ptr <= owner+1 (mod N_PORTS).
- Re-arbitration on mem_resp (no idle turnaround):
  - Pick among pend with the owner masked out, starting at owner+1.
  - If a winner exists, stay BUSY with owner <= winner; else go IDLE.
  - The masked owner's next request is next eligible after a full rotation, or earlier if no other port is pending.
- Latency: a request first seen in IDLE at cycle t appears on mem_* in cycle t+1. Back-to-back owners have zero dead cycles.
- A requester must drop read/write in the cycle after its resp.
- Owner drops its request before mem_resp (illegal): mem_read/mem_write follow it low. The arbiter stays BUSY until mem_resp. Simulation assertion fires.
- Read and write asserted together on one port: illegal, assertion. Both are forwarded unchanged.
- mem_resp while IDLE: ignored. No req_resp, no state change, assertion warning.
- rst asserted mid-transaction: next edge forces IDLE and rr_ptr=0. mem_read/mem_write fall in the cycle after that edge. Any later mem_resp is treated as spurious.
- req_resp is never asserted for more than one port, and never in IDLE.

Decomposition:
- Package l2_arbiter_pkg: state enum (IDLE, BUSY) and an address-width localparam.
- Sub-module rr_picker: combinational, parameter N.
  - Inputs: pend vector, start index, mask vector.
  - Outputs: found, idx.
  - Instantiated twice: idle pick and resp-time pick.

Test Plan:
- Reset, then port0 read @0x100 in cycle 1: mem_read=1 and mem_address=0x100 in cycle 2; grant_idx=0. L2 mem_resp with rdata=0xA5 repeated: req_resp=01, req_rdata=0xA5 that cycle; port1 gets nothing.
- N_PORTS=2, both ports reading continuously: grants alternate 0,1,0,1 over 8 transactions; mem_read stays high with no gap cycle between owners.
- N_PORTS=4, ports 1 and 3 pending, rr_ptr=2: port3 granted first, then port1.
- Port1 write of line 0xDEAD… @0x2000 while port0 idle: mem_write=1, mem_wdata equals port1's data; req_resp=10 on mem_resp.
- mem_resp pulsed in IDLE: req_resp stays 0 and grant_valid stays 0.
- rst asserted in BUSY mid-request: next cycle grant_valid=0 and mem_read=0; after release, port0 is granted first when ports 0 and 1 are pending.
